result_bcd_conv: RTL and testbench

Sequential binary-to-BCD converter between the 8-bit ALU result and the calculator display driver. It accepts one 16-bit ALU result per valid/ready handshake, together with the divide-by-zero flag and a signed-interpretation flag. It converts the magnitude to packed BCD with an iterative shift-add-3 (double-dabble), one bit per cycle. It then holds the digits, sign and error flag for the display stage until that stage acknowledges them.

---
 rtl/result_bcd_conv.sv | 118 +++++++++++
 tb/tb_result_bcd_conv.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/result_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_conv
// Purpose  : Sequential double-dabble converter from ALU result to packed BCD,
//            held for the display stage under a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module result_bcd_conv #(
   parameter int W  = 16,
   parameter int ND = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_value,
   input  logic            in_signed,
   input  logic            in_err,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*ND-1:0] out_bcd,
   output logic            out_neg,
   output logic            out_err
);

   localparam int c_cnt_w = $clog2(W + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t               r_state;
   logic [W-1:0]         r_mag;
   logic [4*ND-1:0]      r_bcd_work;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_neg;
   logic                 r_err;

   logic [4*ND-1:0]      w_adj;
   logic [4*ND-1:0]      w_bcd_shift;
   logic [W-1:0]         w_mag_shift;
   logic [W-1:0]         w_mag_in;
   logic                 w_neg_in;

   generate
      for (genvar g = 0; g < ND; g++) begin : g_digit
         assign w_adj[4*g +: 4] = (r_bcd_work[4*g +: 4] >= 4'd5) ?
                                  r_bcd_work[4*g +: 4] + 4'd3 :
                                  r_bcd_work[4*g +: 4];
      end
   endgenerate

   assign {w_bcd_shift, w_mag_shift} = {w_adj[4*ND-2:0], r_mag, 1'b0};

   assign w_neg_in = in_signed & in_value[W-1];
   assign w_mag_in = w_neg_in ? ((~in_value) + W'(1)) : in_value;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mag      <= '0;
         r_bcd_work <= '0;
         r_cnt      <= '0;
         r_neg      <= 1'b0;
         r_err      <= 1'b0;
         out_bcd    <= '0;
         out_neg    <= 1'b0;
         out_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mag      <= w_mag_in;
                  r_neg      <= w_neg_in;
                  r_err      <= in_err;
                  r_bcd_work <= '0;
                  r_cnt      <= c_cnt_w'(W);
                  r_state    <= S_CONV;
               end
            end
            S_CONV: begin
               // An error result spends one cycle here without iterating.
               if (r_err) begin
                  out_bcd <= '0;
                  out_neg <= 1'b0;
                  out_err <= 1'b1;
                  r_state <= S_HOLD;
               end else begin
                  r_bcd_work <= w_bcd_shift;
                  r_mag      <= w_mag_shift;
                  r_cnt      <= r_cnt - c_cnt_w'(1);
                  if (r_cnt == c_cnt_w'(1)) begin
                     out_bcd <= w_bcd_shift;
                     out_neg <= r_neg;
                     out_err <= 1'b0;
                     r_state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_bcd_conv
// Purpose  : Directed self-checking bench for result_bcd_conv.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_bcd_conv;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_value;
   logic        in_signed;
   logic        in_err;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_bcd;
   logic        out_neg;
   logic        out_err;

   int n_checks = 0;
   int n_errors = 0;

   result_bcd_conv #(.W(16), .ND(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .in_signed (in_signed),
      .in_err    (in_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .out_neg   (out_neg),
      .out_err   (out_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic release_hold(input logic [19:0] eb);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_ready", 32'(in_ready), 32'd1);
      check("release_bcd_kept", 32'(out_bcd), 32'(eb));
   endtask

   task automatic run(input string tag, input logic [15:0] v, input logic s, input logic e,
                      input logic [19:0] eb, input logic en, input logic ee,
                      input int elat, input bit rel);
      int w;
      int lat;
      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      check({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
      in_value  = v;
      in_signed = s;
      in_err    = e;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_value  = 16'h0;
      in_signed = 1'b0;
      in_err    = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(elat));
      check({tag, "_bcd"}, 32'(out_bcd), 32'(eb));
      check({tag, "_neg"}, 32'(out_neg), 32'(en));
      check({tag, "_err"}, 32'(out_err), 32'(ee));
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      if (rel) release_hold(eb);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_value  = 16'h0;
      in_signed = 1'b0;
      in_err    = 1'b0;
      out_ready = 1'b0;
      tick();
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_bcd", 32'(out_bcd), 32'd0);
      check("rst_neg", 32'(out_neg), 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      run("zero",     16'h0000, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 16, 1'b1);
      run("ffff_u",   16'hFFFF, 1'b0, 1'b0, 20'h65535, 1'b0, 1'b0, 16, 1'b1);
      run("ffff_s",   16'hFFFF, 1'b1, 1'b0, 20'h00001, 1'b1, 1'b0, 16, 1'b1);
      run("fffb_s",   16'hFFFB, 1'b1, 1'b0, 20'h00005, 1'b1, 1'b0, 16, 1'b1);
      run("fe01_u",   16'hFE01, 1'b0, 1'b0, 20'h65025, 1'b0, 1'b0, 16, 1'b1);
      run("8000_s",   16'h8000, 1'b1, 1'b0, 20'h32768, 1'b1, 1'b0, 16, 1'b1);
      run("zero_s",   16'h0000, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0, 16, 1'b1);
      run("7fff_s",   16'h7FFF, 1'b1, 1'b0, 20'h32767, 1'b0, 1'b0, 16, 1'b1);
      run("div0",     16'h1234, 1'b0, 1'b1, 20'h00000, 1'b0, 1'b1, 1,  1'b1);

      // -1234 held while upstream keeps pulsing a new value
      run("hold",     16'hFB2E, 1'b1, 1'b0, 20'h01234, 1'b1, 1'b0, 16, 1'b0);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2) == 0;
         in_value = 16'h1111;
         tick();
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_ready", 32'(in_ready), 32'd0);
         check("hold_bcd", 32'(out_bcd), 32'h01234);
         check("hold_neg", 32'(out_neg), 32'd1);
      end
      in_valid = 1'b0;
      in_value = 16'h0;
      release_hold(20'h01234);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_capture_ready", 32'(in_ready), 32'd1);
         check("no_capture_valid", 32'(out_valid), 32'd0);
      end

      // asynchronous reset after the eighth iteration of 0x1234
      in_value = 16'h1234;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_value = 16'h0;
      repeat (8) tick();
      check("mid_busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("arst_ready", 32'(in_ready), 32'd1);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_bcd", 32'(out_bcd), 32'd0);
      check("arst_neg", 32'(out_neg), 32'd0);
      check("arst_err", 32'(out_err), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      run("post_rst", 16'h04D2, 1'b0, 1'b0, 20'h01234, 1'b0, 1'b0, 16, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
